// File: rtl/baud_rate_controller_pkg.sv
// Shared UART definitions: default baud constants and the divisor-update FSM encoding.
package baud_rate_controller_pkg;

  localparam int UART_DIV_WIDTH   = 16;
  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_DEFAULT_DIV = 27;

  typedef enum logic [0:0] {
    BRC_IDLE    = 1'b0,
    BRC_PENDING = 1'b1
  } brc_state_e;

endpackage

// File: rtl/baud_tick_counter.sv
// Loadable divide-by-N counter. wrap is asserted (combinationally) on the
// cycle whose rising edge returns the count to zero, so the period is div cycles.
module baud_tick_counter
  import baud_rate_controller_pkg::*;
#(
  parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 wrap
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 at_end;

  // Next count: clear when disabled or at the end of a period, else increment.
  always_comb begin
    at_end = (cnt_q == (div - DIV_WIDTH'(1)));
    wrap   = enable && at_end;
    if (!enable) begin
      cnt_d = DIV_WIDTH'(0);
    end else if (at_end) begin
      cnt_d = DIV_WIDTH'(0);
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= DIV_WIDTH'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_rate_controller.sv
// Baud tick source: oversample/bit ticks from a runtime divisor. New divisors
// arrive over valid/ready and take effect only on a bit boundary (or at once
// while disabled), so a bit in flight is never shortened or stretched.
module baud_rate_controller
  import baud_rate_controller_pkg::*;
#(
  parameter int DIV_WIDTH   = UART_DIV_WIDTH,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_error,
  output logic                 upd_done,
  output logic [DIV_WIDTH-1:0] active_div,
  output logic                 os_tick,
  output logic                 bit_tick
);

  localparam int                   PHASE_W    = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST    = DIV_WIDTH'(DEFAULT_DIV);

  logic                 wrap;
  logic                 bit_wrap;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   phase_d;
  logic                 os_tick_q;
  logic                 os_tick_d;
  logic                 bit_tick_q;
  logic                 bit_tick_d;
  brc_state_e           state_q;
  logic [DIV_WIDTH-1:0] pending_div_q;
  logic [DIV_WIDTH-1:0] active_div_q;
  logic                 cfg_ready_q;
  logic                 cfg_error_q;
  logic                 upd_done_q;

  baud_tick_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .div    (active_div_q),
    .wrap   (wrap)
  );

  // Phase advance and tick generation; a bit boundary is the wrap on the last phase.
  always_comb begin
    bit_wrap   = wrap && (phase_q == PHASE_LAST);
    os_tick_d  = wrap;
    bit_tick_d = bit_wrap;
    if (!enable) begin
      phase_d = PHASE_W'(0);
    end else if (bit_wrap) begin
      phase_d = PHASE_W'(0);
    end else if (wrap) begin
      phase_d = phase_q + PHASE_W'(1);
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase counter and registered tick outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q    <= PHASE_W'(0);
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  // Divisor handshake FSM: accept in IDLE, swap in on the next bit boundary or when disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BRC_IDLE;
      pending_div_q <= DIV_WIDTH'(0);
      active_div_q  <= DIV_RST;
      cfg_ready_q   <= 1'b1;
      cfg_error_q   <= 1'b0;
      upd_done_q    <= 1'b0;
    end else begin
      cfg_error_q <= 1'b0;
      upd_done_q  <= 1'b0;
      case (state_q)
        BRC_IDLE: begin
          if (cfg_valid) begin
            if (cfg_div == DIV_WIDTH'(0)) begin
              cfg_error_q <= 1'b1;
            end else begin
              pending_div_q <= cfg_div;
              state_q       <= BRC_PENDING;
              cfg_ready_q   <= 1'b0;
            end
          end
        end
        BRC_PENDING: begin
          if (!enable || bit_wrap) begin
            active_div_q <= pending_div_q;
            upd_done_q   <= 1'b1;
            state_q      <= BRC_IDLE;
            cfg_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= BRC_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_error  = cfg_error_q;
  assign upd_done   = upd_done_q;
  assign active_div = active_div_q;
  assign os_tick    = os_tick_q;
  assign bit_tick   = bit_tick_q;

endmodule

// File: doc/baud_rate_controller.md
Name: baud_rate_controller

Overview:
Runtime-configurable baud tick source for the UART peripheral.
- Owns a loadable divide-by-N counter and produces a 1-cycle oversample tick (os_tick) plus a 1-cycle bit tick (bit_tick) every OVERSAMPLE oversample ticks.
- Accepts new divisors over a valid/ready handshake.
- Applies a new divisor only on a bit boundary, so a frame in flight never sees a shortened or stretched bit.
- Sits between the peripheral register interface and the UART tx/rx engines.

Parameters:
DIV_WIDTH, 16, width of divisor and divide counter
OVERSAMPLE, 16, oversample ticks per bit_tick (>=2)
DEFAULT_DIV, 27, divisor loaded at reset (>=1, fits DIV_WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
enable  input  1  1 = run ticks; 0 = clear counters, suppress ticks
cfg_valid  input  1  new divisor offered
cfg_div  input  DIV_WIDTH  offered divisor
cfg_ready  output  1  controller can accept a divisor
cfg_error  output  1  1-cycle pulse: accepted divisor was 0, discarded
upd_done  output  1  1-cycle pulse: pending divisor became active
active_div  output  DIV_WIDTH  divisor currently in use
os_tick  output  1  oversample tick, 1 cycle wide, registered
bit_tick  output  1  bit tick, 1 cycle wide, registered, coincident with an os_tick

Behaviour:
- Reset (reset==0 at an edge): active_div=DEFAULT_DIV, cnt=0, phase=0, os_tick=bit_tick=0, cfg_ready=1, cfg_error=upd_done=0, state=IDLE, pending divisor discarded.
- Counter, per edge with enable==1:
  - If cnt==active_div-1: cnt<=0, os_tick<=1, phase<=phase+1 (wraps at OVERSAMPLE-1→0). bit_tick<=1 iff phase==OVERSAMPLE-1.
  - Else: cnt<=cnt+1, os_tick<=0, bit_tick<=0.
  - os_tick period is exactly active_div cycles. With active_div==1, os_tick is high every cycle.
- Per edge with enable==0: cnt<=0, phase<=0, os_tick<=0, bit_tick<=0.
- After enable rises, the first os_tick is visible after the active_div-th edge at which enable was sampled high.
- Handshake: a divisor is accepted when cfg_valid&&cfg_ready at an edge. cfg_div is sampled only at acceptance.
- FSM IDLE (cfg_ready=1):
  - Accept with cfg_div==0: cfg_error<=1 for one cycle, stay IDLE, active_div unchanged.
  - Accept with cfg_div!=0: store pending_div, go to PENDING.
- FSM PENDING (cfg_ready=0):
  - At the edge that sets bit_tick<=1: active_div<=pending_div, upd_done<=1, go to IDLE. cnt is already 0 there, so the next period uses the new divisor.
  - If enable==0 at an edge: apply immediately the same way (upd_done<=1, go to IDLE).
  - An acceptance and a bit boundary at the same edge: the new divisor waits for the next bit boundary.
  - cfg_valid is ignored while in PENDING.
- upd_done and cfg_error are each high for exactly one cycle. They are never asserted together.
- Reset mid-PENDING: pending divisor lost, no upd_done.
- Arithmetic: cnt and active_div are DIV_WIDTH bits and the compare is unsigned. phase is clog2(OVERSAMPLE) bits.

Decomposition:
- Shared uart package holds:
  - FSM state encoding (IDLE, PENDING)
  - default DIV_WIDTH, OVERSAMPLE and DEFAULT_DIV constants, also used by the tx/rx engines
- One sub-module, baud_tick_counter:
  - loadable divide-by-N counter with enable
  - emits the wrap pulse
- Phase counter, FSM and handshake stay in the top level.

Test Plan (DEFAULT_DIV=4, OVERSAMPLE=4, DIV_WIDTH=8):
1. Hold reset=0 3 cycles, then reset=1, enable=1 → os_tick high after edge 4, then every 4 cycles; bit_tick every 16 cycles, first after edge 16; active_div=4, cfg_ready=1.
2. Running, offer cfg_div=2 mid-bit → cfg_ready=0 until the next bit_tick; os_tick period stays 4 until then; upd_done pulses with that bit_tick; afterwards os_tick every 2 cycles, bit_tick every 8; active_div=2.
3. Offer cfg_div=0 in IDLE → accepted, cfg_error pulses 1 cycle, cfg_ready stays 1, active_div and tick timing unchanged, no upd_done.
4. Offer cfg_div=6, then drop enable before the bit boundary → upd_done on the edge after enable sampled 0; os_tick=bit_tick=0, cnt=phase=0; on re-enable the first os_tick arrives after 6 edges.
5. Configure cfg_div=1 → after upd_done, os_tick high every cycle and bit_tick every 4 cycles.
6. Offer cfg_div=9, then assert reset=0 while PENDING → active_div=4, cfg_ready=1, no upd_done; after release, tick timing matches scenario 1.
